// File: rtl/quad_encoder_gen.sv
`default_nettype none
// ============================================================================
// Module   : quad_encoder_gen
// Purpose  : Emulates a rotary quadrature encoder with push switch. Rotation
//            commands emit N detent steps as a four-phase Gray sequence on
//            oA/oB. Press commands pull oSW low for a fixed hold time.
// Revision : 1.0 - initial release
// ============================================================================
module quad_encoder_gen #(
  parameter int PHASE_TICKS = 50000,
  parameter int PRESS_TICKS = 100000,
  parameter int GAP_TICKS   = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic       cmd_dir,
  input  logic [7:0] cmd_count,
  output logic       cmd_ready,
  input  logic       press_valid,
  output logic       press_ready,
  output logic       oA,
  output logic       oB,
  output logic       oSW,
  output logic       busy,
  output logic       done
);

  // Tick counters are sized for the longest of the three intervals.
  localparam int MAX_RG = (PHASE_TICKS > GAP_TICKS) ? PHASE_TICKS : GAP_TICKS;
  localparam int MAX_T  = (MAX_RG > PRESS_TICKS) ? MAX_RG : PRESS_TICKS;
  localparam int TW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [TW-1:0] C_PH_LAST  = TW'(PHASE_TICKS - 1);
  localparam logic [TW-1:0] C_GAP_LAST = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0] C_PR_LAST  = TW'(PRESS_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PH1  = 3'd1,
    S_PH2  = 3'd2,
    S_PH3  = 3'd3,
    S_PH4  = 3'd4,
    S_GAP  = 3'd5
  } rot_state_t;

  typedef enum logic {
    P_IDLE = 1'b0,
    P_HOLD = 1'b1
  } press_state_t;

  rot_state_t   rstate_q, rstate_d;
  press_state_t pstate_q, pstate_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [TW-1:0] ptick_q, ptick_d;
  logic [7:0]    rem_q, rem_d;
  logic          dir_q, dir_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          a_q, b_q, sw_q;
  logic [1:0]    w_pins;
  logic          w_cmd_acc, w_press_acc;

  // Pin pattern for a rotation state; CCW is CW with A and B swapped, so the
  // sequence stays Gray-coded in both directions (idle/gap/PH4 are all 00).
  function automatic logic [1:0] f_pins(input rot_state_t s, input logic dir);
    logic [1:0] cw;
    case (s)
      S_PH1:   cw = 2'b10;
      S_PH2:   cw = 2'b11;
      S_PH3:   cw = 2'b01;
      default: cw = 2'b00;
    endcase
    return dir ? {cw[0], cw[1]} : cw;
  endfunction

  // ready_q is high only when both channels idle. A simultaneous rotation
  // request masks press_ready so rotation wins arbitration.
  assign w_cmd_acc   = cmd_valid & ready_q;
  assign w_press_acc = press_valid & ready_q & ~cmd_valid;

  // Next-state logic for the rotation and press channels.
  always_comb begin
    rstate_d = rstate_q;
    pstate_d = pstate_q;
    tick_d   = tick_q + TW'(1);
    ptick_d  = ptick_q + TW'(1);
    rem_d    = rem_q;
    dir_d    = dir_q;
    done_d   = 1'b0;

    case (rstate_q)
      S_IDLE: begin
        tick_d = '0;
        if (w_cmd_acc) begin
          dir_d = cmd_dir;
          rem_d = cmd_count;
          if (cmd_count == 8'd0) begin
            done_d = 1'b1;
          end else begin
            rstate_d = S_PH1;
          end
        end
      end
      S_PH1, S_PH2, S_PH3: begin
        if (tick_q == C_PH_LAST) begin
          tick_d   = '0;
          rstate_d = rot_state_t'(rstate_q + 3'd1);
        end
      end
      S_PH4: begin
        if (tick_q == C_PH_LAST) begin
          tick_d = '0;
          rem_d  = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            rstate_d = S_IDLE;
            done_d   = 1'b1;
          end else begin
            rstate_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (tick_q == C_GAP_LAST) begin
          tick_d   = '0;
          rstate_d = S_PH1;
        end
      end
      default: begin
        tick_d   = '0;
        rstate_d = S_IDLE;
      end
    endcase

    case (pstate_q)
      P_IDLE: begin
        ptick_d = '0;
        if (w_press_acc) begin
          pstate_d = P_HOLD;
        end
      end
      default: begin
        if (ptick_q == C_PR_LAST) begin
          ptick_d  = '0;
          pstate_d = P_IDLE;
          done_d   = 1'b1;
        end
      end
    endcase

    ready_d = (rstate_d == S_IDLE) && (pstate_d == P_IDLE);
    busy_d  = ~ready_d;
    w_pins  = f_pins(rstate_d, dir_d);
  end

  // State and registered outputs; reset forces the safe idle pin levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate_q <= S_IDLE;
      pstate_q <= P_IDLE;
      tick_q   <= '0;
      ptick_q  <= '0;
      rem_q    <= 8'd0;
      dir_q    <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      sw_q     <= 1'b1;
    end else begin
      rstate_q <= rstate_d;
      pstate_q <= pstate_d;
      tick_q   <= tick_d;
      ptick_q  <= ptick_d;
      rem_q    <= rem_d;
      dir_q    <= dir_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      a_q      <= w_pins[1];
      b_q      <= w_pins[0];
      sw_q     <= (pstate_d != P_HOLD);
    end
  end

  assign cmd_ready   = ready_q;
  assign press_ready = ready_q & ~cmd_valid;
  assign oA          = a_q;
  assign oB          = b_q;
  assign oSW         = sw_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_encoder_gen
// Purpose  : Self-checking bench for quad_encoder_gen. Each vector pushes the
//            expected per-cycle output trace to a queue when it is launched;
//            the trace is popped and compared cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quad_encoder_gen;

  localparam int PHASE = 4;
  localparam int GAP   = 2;
  localparam int PRESS = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_dir = 1'b0;
  logic [7:0] cmd_count = 8'd0;
  logic       press_valid = 1'b0;
  logic       cmd_ready, press_ready, oA, oB, oSW, busy, done;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic a, b, sw, busy, done, rdy;
  } exp_t;

  typedef struct {
    string      name;
    logic       is_press;
    logic       both;
    logic       dir;
    logic [7:0] count;
    int         hold_cmd;
    int         exp_busy;
    int         exp_swlow;
  } vec_t;

  exp_t exp_q[$];

  quad_encoder_gen #(
    .PHASE_TICKS(PHASE),
    .PRESS_TICKS(PRESS),
    .GAP_TICKS  (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_dir    (cmd_dir),
    .cmd_count  (cmd_count),
    .cmd_ready  (cmd_ready),
    .press_valid(press_valid),
    .press_ready(press_ready),
    .oA         (oA),
    .oB         (oB),
    .oSW        (oSW),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [1:0] pins(input int ph, input logic dir);
    logic [1:0] cw;
    case (ph)
      1:       cw = 2'b10;
      2:       cw = 2'b11;
      3:       cw = 2'b01;
      default: cw = 2'b00;
    endcase
    return dir ? {cw[0], cw[1]} : cw;
  endfunction

  task automatic push(input logic [1:0] ab, input logic sw, input logic bz,
                      input logic dn, input logic rdy);
    exp_t e;
    e = '{a: ab[1], b: ab[0], sw: sw, busy: bz, done: dn, rdy: rdy};
    exp_q.push_back(e);
  endtask

  task automatic push_rot(input logic dir, input logic [7:0] count);
    for (int s = 0; s < int'(count); s++) begin
      for (int p = 1; p <= 4; p++)
        repeat (PHASE) push(pins(p, dir), 1'b1, 1'b1, 1'b0, 1'b0);
      if (s < int'(count) - 1)
        repeat (GAP) push(2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    push(2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
    push(2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic push_press();
    repeat (PRESS) push(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    push(2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
    push(2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  // Pops one expected entry per cycle; scrambles cmd_dir/cmd_count to show
  // a running command ignores them, and holds cmd_valid for hold_cmd cycles.
  task automatic drain(input string name, input int hold_cmd, output int busy_n,
                       output int done_n, output int sw_n, output int gray_bad);
    logic pa, pb;
    exp_t e;
    int   i;
    logic [6:0] act, expv;
    busy_n = 0; done_n = 0; sw_n = 0; gray_bad = 0; i = 0;
    pa = oA; pb = oB;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e    = exp_q.pop_front();
      act  = {oA, oB, oSW, busy, done, cmd_ready, press_ready};
      expv = {e.a, e.b, e.sw, e.busy, e.done, e.rdy, e.rdy & ~cmd_valid};
      checks++;
      if (act !== expv) begin
        failures++;
        $display("FAIL %s cycle %0d: got {A,B,SW,busy,done,crdy,prdy}=%b expected %b",
                 name, i, act, expv);
      end
      if (busy) busy_n++;
      if (done) done_n++;
      if (!oSW) sw_n++;
      if ((oA != pa) && (oB != pb)) gray_bad++;
      pa = oA; pb = oB;
      press_valid = 1'b0;
      cmd_valid   = (i < hold_cmd);
      cmd_dir     = 1'($urandom);
      cmd_count   = 8'($urandom);
      i++;
    end
  endtask

  initial begin
    vec_t vecs[6];
    int bn, dn, sn, gb;

    vecs[0] = '{"cw1",    1'b0, 1'b0, 1'b0, 8'd1,   0, 16,   0};
    vecs[1] = '{"ccw3",   1'b0, 1'b0, 1'b1, 8'd3,   0, 52,   0};
    vecs[2] = '{"cnt0",   1'b0, 1'b0, 1'b0, 8'd0,   0, 0,    0};
    vecs[3] = '{"press",  1'b1, 1'b0, 1'b0, 8'd0,   3, 6,    6};
    vecs[4] = '{"both",   1'b0, 1'b1, 1'b0, 8'd2,   0, 34,   0};
    vecs[5] = '{"cw255",  1'b0, 1'b0, 1'b0, 8'd255, 0, 4588, 0};

    // Asynchronous reset values, before any clock edge.
    #1 rst = 1'b1;
    #2;
    chk("reset_outs", {oA, oB, oSW, busy, done, cmd_ready, press_ready}, 7'b0010000);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_cmd_ready", cmd_ready, 1'b1);
    chk("post_reset_press_ready", press_ready, 1'b1);

    for (int v = 0; v < 6; v++) begin
      chk({vecs[v].name, "_idle_ready"}, cmd_ready, 1'b1);
      cmd_dir   = vecs[v].dir;
      cmd_count = vecs[v].count;
      if (vecs[v].is_press) begin
        press_valid = 1'b1;
        push_press();
      end else begin
        cmd_valid   = 1'b1;
        press_valid = vecs[v].both;
        push_rot(vecs[v].dir, vecs[v].count);
      end
      #1;
      if (vecs[v].both) chk("both_press_ready_masked", press_ready, 1'b0);
      drain(vecs[v].name, vecs[v].hold_cmd, bn, dn, sn, gb);
      chk({vecs[v].name, "_busy_cycles"}, bn, vecs[v].exp_busy);
      chk({vecs[v].name, "_done_pulses"}, dn, 1);
      chk({vecs[v].name, "_sw_low_cycles"}, sn, vecs[v].exp_swlow);
      chk({vecs[v].name, "_gray"}, gb, 0);
    end

    // Reset during PH2 aborts the command without a done pulse.
    cmd_dir = 1'b0; cmd_count = 8'd2; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (PHASE) @(negedge clk);
    chk("in_ph2_pins", {oA, oB}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("midrun_reset_outs", {oA, oB, oSW, busy, done, cmd_ready, press_ready}, 7'b0010000);
    dn = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("midrun_reset_no_done", dn, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rerun_ready", cmd_ready, 1'b1);
    cmd_dir = 1'b0; cmd_count = 8'd1; cmd_valid = 1'b1;
    push_rot(1'b0, 8'd1);
    drain("after_reset", 0, bn, dn, sn, gb);
    chk("after_reset_busy_cycles", bn, 16);
    chk("after_reset_done_pulses", dn, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
